alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_pipe.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 registers the operand bundle (a, b, S, Cin).
//   Stage 2 registers the computed result d and the flags Cout, V, Z, N.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready does not depend on in_valid)
//   a, b, S, Cin        operands, opcode, carry-in (Cin used by add/sub only)
//   out_valid/out_ready output handshake
//   d, Cout, V, Z, N    result and flags, stable while stalled
//   clr_sticky          clears V_sticky (a simultaneous V=1 transfer wins)
//   V_sticky            set by any delivered result with V=1
//   res_count           delivered-result counter, wraps
// Opcodes: 000 xor, 001 xnor, 010 add, 011 sub, 100 or, 101 nor, 110 and,
//          111 signed set-less-than.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       S,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             N,
  input  logic             clr_sticky,
  output logic             V_sticky,
  output logic [CNTW-1:0]  res_count
);

  localparam int MSB = WIDTH - 1;

  logic             r_v1;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_s;
  logic             r_cin;

  logic             r_v2;
  logic [WIDTH-1:0] r_d;
  logic             r_cout;
  logic             r_ovf;
  logic             r_z;
  logic             r_n;

  logic             r_sticky;
  logic [CNTW-1:0]  r_cnt;

  logic             w_out_xfer;
  logic             w_adv1;
  logic             w_in_xfer;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_d;
  logic             w_cout;
  logic             w_ovf;

  assign w_out_xfer = r_v2 & out_ready;
  // Stage 1 may move into stage 2 when stage 2 is empty or being drained.
  assign w_adv1     = r_v1 & (~r_v2 | w_out_xfer);
  // Held low during reset so nothing is accepted in a reset cycle.
  assign in_ready   = ~reset & (~r_v1 | w_adv1);
  assign w_in_xfer  = in_valid & in_ready;

  always_comb begin
    w_bop  = (r_s == 3'b011) ? ~r_b : r_b;
    w_sum  = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, r_cin};
    w_d    = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (r_s)
      3'b000: w_d = r_a ^ r_b;
      3'b001: w_d = ~(r_a ^ r_b);
      3'b010,
      3'b011: begin
        w_d    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        // Signed overflow: operands agree in sign but the result does not.
        w_ovf  = (r_a[MSB] == w_bop[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      3'b100: w_d = r_a | r_b;
      3'b101: w_d = ~(r_a | r_b);
      3'b110: w_d = r_a & r_b;
      3'b111: w_d = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_cin    <= 1'b0;
      r_v2     <= 1'b0;
      r_d      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_in_xfer) begin
        r_v1  <= 1'b1;
        r_a   <= a;
        r_b   <= b;
        r_s   <= S;
        r_cin <= Cin;
      end else if (w_adv1) begin
        r_v1 <= 1'b0;
      end

      if (w_adv1) begin
        r_v2   <= 1'b1;
        r_d    <= w_d;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_z    <= (w_d == '0);
        r_n    <= w_d[MSB];
      end else if (w_out_xfer) begin
        r_v2 <= 1'b0;
      end

      if (w_out_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Set has priority over clear.
      if (w_out_xfer && r_ovf) begin
        r_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign out_valid = r_v2;
  assign d         = r_d;
  assign Cout      = r_cout;
  assign V         = r_ovf;
  assign Z         = r_z;
  assign N         = r_n;
  assign V_sticky  = r_sticky;
  assign res_count = r_cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: a 32-bit instance for the main scenarios and an
// 8-bit instance (CNTW=4) for narrow-width arithmetic and counter wrap.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, out_ready, Cin, clr_sticky;
  logic [31:0] a, b;
  logic [2:0]  S;
  logic        in_ready, out_valid, Cout, V, Z, N, V_sticky;
  logic [31:0] d;
  logic [15:0] res_count;

  logic       in_valid8, out_ready8, Cin8, clr8;
  logic [7:0] a8, b8;
  logic [2:0] S8;
  logic       in_ready8, out_valid8, Cout8, V8, Z8, N8, Vs8;
  logic [7:0] d8;
  logic [3:0] cnt8;

  alu_pipe #(.WIDTH(32), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .S(S), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .Cout(Cout), .V(V), .Z(Z), .N(N), .clr_sticky(clr_sticky),
    .V_sticky(V_sticky), .res_count(res_count)
  );

  alu_pipe #(.WIDTH(8), .CNTW(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .S(S8), .Cin(Cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .d(d8), .Cout(Cout8), .V(V8), .Z(Z8), .N(N8), .clr_sticky(clr8),
    .V_sticky(Vs8), .res_count(cnt8)
  );

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic exp_sticky = 1'b0;
  logic [35:0] exp_q[$];

  // Reference: {d[31:0], cout, v, z, n} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                        input logic [2:0] is, input logic icin);
    logic [31:0] rd, bb;
    logic        c, v;
    longint unsigned full;
    longint      sres;
    int          sa, sb;
    c = 1'b0; v = 1'b0; rd = '0;
    case (is)
      3'd0: rd = ia ^ ib;
      3'd1: rd = ~(ia ^ ib);
      3'd4: rd = ia | ib;
      3'd5: rd = ~(ia | ib);
      3'd6: rd = ia & ib;
      3'd7: begin
        sa = ia; sb = ib;
        rd = (sa < sb) ? 32'd1 : 32'd0;
      end
      default: begin
        bb   = (is == 3'd2) ? ib : ~ib;
        full = 64'(ia) + 64'(bb) + 64'(icin);
        rd   = full[31:0];
        c    = full[32];
        sa = ia; sb = bb;
        sres = longint'(sa) + longint'(sb) + longint'(icin);
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
    endcase
    return {rd, c, v, (rd == 32'd0), rd[31]};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    exp_q.delete();
  endtask

  // Sends one bundle into an empty pipe with out_ready=1 and returns the
  // result seen on the outputs plus the number of rising edges from the
  // accepting edge to the first cycle with out_valid=1 (inclusive).
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] is,
                       input logic icin, input logic iclr, output logic [35:0] obs,
                       output int lat);
    int guard;
    @(negedge clk);
    a = ia; b = ib; S = is; Cin = icin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    obs = {d, Cout, V, Z, N};
    clr_sticky = iclr;
    @(posedge clk);
    @(negedge clk);
    clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; a = 32'h1234; b = 32'h1; S = 3'd2; Cin = 1'b0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; S8 = '0; Cin8 = 1'b0; out_ready8 = 1'b1; clr8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({out_valid, V_sticky, res_count} !== 18'd0) begin
      errors++; $display("FAIL reset_state: out_valid=%b V_sticky=%b res_count=%0d want 0,0,0", out_valid, V_sticky, res_count);
    end
    checks++;
    if ({d, Cout, V, Z, N} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs: d=%h flags=%b want 0", d, {Cout, V, Z, N});
    end
    checks++;
    if ({out_valid8, cnt8} !== 5'd0) begin
      errors++; $display("FAIL reset_w8: out_valid=%b cnt=%0d want 0,0", out_valid8, cnt8);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    // A bundle offered during reset must not have been accepted.
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: out_valid=%b want 0", out_valid); end
    exp_cnt = 0; exp_sticky = 1'b0;
  endtask

  task automatic test_add_carry();
    logic [35:0] obs; int lat;
    do_op(32'h0FFFFFFF, 32'h0, 3'd2, 1'b1, 1'b0, obs, lat);
    exp_cnt++;
    checks++;
    if (obs[35:2] !== {32'h10000000, 2'b00}) begin
      errors++; $display("FAIL add_carry: d=%h Cout=%b V=%b want 10000000,0,0", obs[35:4], obs[3], obs[2]);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d edges want 2", lat); end
    checks++;
    if (res_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL add_count: got %0d want %0d", res_count, exp_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [35:0] obs; int lat;
    do_op(32'h7FFFFFFF, 32'h0, 3'd2, 1'b1, 1'b0, obs, lat);
    exp_cnt++; exp_sticky = 1'b1;
    checks++;
    if ({obs[35:4], obs[2], obs[0]} !== {32'h80000000, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ovf_add: d=%h V=%b N=%b want 80000000,1,1", obs[35:4], obs[2], obs[0]);
    end
    checks++;
    if (V_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set: got %b want 1", V_sticky); end
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 1'b0, 1'b0, obs, lat);
    exp_cnt++;
    checks++;
    if (obs[35:2] !== {32'hFFFFFFFE, 2'b10}) begin
      errors++; $display("FAIL carry_no_ovf: d=%h Cout=%b V=%b want fffffffe,1,0", obs[35:4], obs[3], obs[2]);
    end
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    checks++;
    if (V_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b want 0", V_sticky); end
    do_op(32'h7FFFFFFF, 32'h0, 3'd2, 1'b1, 1'b1, obs, lat);
    exp_cnt++; exp_sticky = 1'b1;
    checks++;
    if (V_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b want 1", V_sticky); end
    checks++;
    if (res_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL ovf_count: got %0d want %0d", res_count, exp_cnt);
    end
  endtask

  task automatic test_sub_slt();
    logic [35:0] obs; int lat;
    do_op(32'h31312020, 32'h33112200, 3'd3, 1'b1, 1'b0, obs, lat);
    exp_cnt++;
    checks++;
    if (obs[35:3] !== {32'hFE1FFE20, 1'b0}) begin
      errors++; $display("FAIL sub: d=%h Cout=%b want fe1ffe20,0", obs[35:4], obs[3]);
    end
    do_op(32'h80000000, 32'h00000001, 3'd7, 1'b0, 1'b0, obs, lat);
    exp_cnt++;
    checks++;
    if ({obs[35:4], obs[1]} !== {32'h1, 1'b0}) begin
      errors++; $display("FAIL slt_neg: d=%h Z=%b want 00000001,0", obs[35:4], obs[1]);
    end
    do_op(32'h00000001, 32'h80000000, 3'd7, 1'b0, 1'b0, obs, lat);
    exp_cnt++;
    checks++;
    if (obs[35:4] !== 32'h0) begin errors++; $display("FAIL slt_pos: d=%h want 00000000", obs[35:4]); end
    do_op(32'h5A5AA5A5, 32'h5A5AA5A5, 3'd7, 1'b1, 1'b0, obs, lat);
    exp_cnt++;
    checks++;
    if ({obs[35:4], obs[1]} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL slt_equal: d=%h Z=%b want 00000000,1", obs[35:4], obs[1]);
    end
  endtask

  task automatic test_backpressure();
    int sent, got, cyc;
    logic hold_valid;
    logic [35:0] hold_val, exp;
    logic [2:0] pat_idx;
    pulse_reset();
    sent = 0; got = 0; cyc = 0; hold_valid = 1'b0; hold_val = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      pat_idx = 3'(cyc % 4);
      out_ready = (pat_idx == 3'd0) || (pat_idx == 3'd3);
      in_valid = (sent < 8);
      a = $urandom; b = $urandom; S = 3'($urandom_range(0, 7)); Cin = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, S, Cin));
        sent++;
      end
      if (out_valid) begin
        if (hold_valid) begin
          checks++;
          if ({d, Cout, V, Z, N} !== hold_val) begin
            errors++; $display("FAIL bp_stall_hold: got %h want %h", {d, Cout, V, Z, N}, hold_val);
          end
        end
        if (out_ready) begin
          hold_valid = 1'b0;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hX;
          checks++;
          if ({d, Cout, V, Z, N} !== exp) begin
            errors++; $display("FAIL bp_result %0d: got %h want %h", got, {d, Cout, V, Z, N}, exp);
          end
          got++; exp_cnt++;
          if (exp[2]) exp_sticky = 1'b1;
        end else begin
          hold_valid = 1'b1;
          hold_val = {d, Cout, V, Z, N};
        end
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 8) begin errors++; $display("FAIL bp_timeout: delivered %0d want 8", got); end
    checks++;
    if (res_count !== 16'd8) begin errors++; $display("FAIL bp_count: got %0d want 8", res_count); end
  endtask

  task automatic test_random();
    int cyc;
    logic [35:0] exp;
    logic xfer_v;
    cyc = 0;
    while ((cyc < 300 || exp_q.size() > 0 || out_valid) && cyc < 500) begin
      @(negedge clk);
      checks++;
      if ({V_sticky, res_count} !== {exp_sticky, 16'(exp_cnt)}) begin
        errors++; $display("FAIL rand_status cyc %0d: sticky=%b count=%0d want %b,%0d", cyc, V_sticky, res_count, exp_sticky, exp_cnt);
      end
      if (cyc < 300) begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 9) < 7);
        clr_sticky = ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
      end
      a = $urandom; b = $urandom; S = 3'($urandom_range(0, 7)); Cin = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, S, Cin));
      xfer_v = 1'b0;
      if (out_valid && out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hX;
        checks++;
        if ({d, Cout, V, Z, N} !== exp) begin
          errors++; $display("FAIL rand_result cyc %0d: got %h want %h", cyc, {d, Cout, V, Z, N}, exp);
        end
        exp_cnt++;
        xfer_v = exp[2];
      end
      if (xfer_v) exp_sticky = 1'b1;
      else if (clr_sticky) exp_sticky = 1'b0;
      cyc++;
    end
    @(negedge clk);
    clr_sticky = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d results missing want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; S = 3'd2; a = 32'h11; b = 32'h22; Cin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_full: out_valid=%b in_ready=%b want 1,0", out_valid, in_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if ({out_valid, V_sticky, res_count} !== 18'd0) begin
      errors++; $display("FAIL mid_reset_state: out_valid=%b sticky=%b count=%0d want 0,0,0", out_valid, V_sticky, res_count);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_cnt = 0; exp_sticky = 1'b0; exp_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale %0d: out_valid=%b want 0", i, out_valid); end
    end
    checks++;
    if (res_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", res_count); end
  endtask

  task automatic test_width8();
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; S8 = 3'd2; Cin8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid8, d8, V8} !== {1'b1, 8'h80, 1'b1}) begin
      errors++; $display("FAIL w8_add: valid=%b d=%h V=%b want 1,80,1", out_valid8, d8, V8);
    end
    in_valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; S8 = 3'd5;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid8, d8, Z8} !== {1'b1, 8'h00, 1'b1}) begin
      errors++; $display("FAIL w8_nor: valid=%b d=%h Z=%b want 1,00,1", out_valid8, d8, Z8);
    end
    // 15 more results take the 4-bit counter from 2 past 15 to 1.
    for (int i = 0; i < 15; i++) begin
      in_valid8 = 1'b1; a8 = 8'(i); b8 = 8'h3; S8 = 3'd2;
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cnt8 !== 4'd1) begin errors++; $display("FAIL w8_count_wrap: got %0d want 1", cnt8); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    a = '0; b = '0; S = '0; Cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; clr8 = 1'b0;
    a8 = '0; b8 = '0; S8 = '0; Cin8 = 1'b0;
    test_reset();
    test_add_carry();
    test_overflow();
    test_sub_slt();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
